hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the SELEN 5-stage core.
- Generates the hold, flush and bubble controls that the decode and execute pipeline registers consume: enb* (1 = hold), flash* (1 = clear), nop_gen (1 = bubble).
- Also generates the execute-stage forwarding selects.
- Tracks multi-cycle data-memory waits with an FSM, a timeout counter and a stall performance counter.

Parameters:
WAIT_MAX, 255, max MEM_WAIT cycles before timeout (1..255, fits 8-bit counter)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset; one clock, synchronous, active-high
rs1D  in  5  decode-stage source 1
rs2D  in  5  decode-stage source 2
rs1E  in  5  execute-stage source 1
rs2E  in  5  execute-stage source 2
rdE  in  5  execute-stage destination
we_regE  in  1  E writes register file
ldE  in  1  E instruction is a load
rdM  in  5  memory-stage destination
we_regM  in  1  M writes register file
rdW  in  5  writeback-stage destination
we_regW  in  1  W writes register file
brch_takenE  in  1  branch/jump resolved taken in E
dmem_req  in  1  M stage issues data-memory access
dmem_ack  in  1  data memory completes access this cycle
enbF  out  1  hold PC/fetch
enbD  out  1  hold decode register
enbE  out  1  hold execute register
flashD  out  1  clear decode register
flashE  out  1  clear execute register
nop_gen  out  1  bubble request to execute register
fwd_aE  out  2  src A select: 00 reg, 01 from M, 10 from W
fwd_bE  out  2  src B select, same encoding
mem_err  out  1  sticky data-memory timeout flag
stall_cnt  out  32  count of cycles with enbF=1

Behaviour:
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when dmem_req=1 and dmem_ack=0.
  - MEM_WAIT -> RUN when dmem_ack=1, or when wait_cnt==WAIT_MAX-1 (timeout).
- wait_cnt (8-bit):
  - Cleared on entering MEM_WAIT and in RUN.
  - Increments each MEM_WAIT cycle without ack.
- mem_err: set on the timeout transition; held until rst.
- memwait = (RUN & dmem_req & ~dmem_ack) | (MEM_WAIT & ~dmem_ack & ~timeout). A same-cycle ack costs zero stall cycles.
- Forwarding (combinational):
  - fwd_aE = 01 if we_regM & rdM!=0 & rdM==rs1E.
  - Otherwise 10 if we_regW & rdW!=0 & rdW==rs1E.
  - Otherwise 00. M has priority over W. fwd_bE is the same using rs2E.
- Load-use (ldu) = ldE & we_regE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
- Combinational output priority, highest first:
  1. rst: enbF=enbD=enbE=0, flashD=flashE=1, nop_gen=0.
  2. memwait: enbF=enbD=enbE=1, flashD=flashE=0, nop_gen=1. A branch in E is frozen and resolves after the wait.
  3. brch_takenE: enbF=enbD=enbE=0, flashD=flashE=1. Overrides ldu, since the D instruction is wrong-path.
  4. ldu: enbF=enbD=1, enbE=0, flashE=1, flashD=0. Exactly one bubble per load-use pair.
  5. Otherwise all outputs 0.
- stall_cnt increments on every cycle with enbF=1 and rst=0; wraps 0xFFFFFFFF -> 0.
- Reset values: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0. Forwarding outputs are 00 whenever inputs give no match.
- rst asserted during MEM_WAIT: next cycle state=RUN, with no mem_err and no count.
- Zero-register writes never forward and never cause a load-use stall.

Test Plan:
- ldE=1, we_regE=1, rdE=5, rs1D=5 -> for one cycle: enbF=enbD=1, flashE=1, enbE=0. Next cycle (ldE=0) all outputs 0. stall_cnt=1.
- rdM=3/we_regM=1 and rdW=3/we_regW=1 with rs1E=3, rs2E=3 -> fwd_aE=fwd_bE=01. Set rdM=0 -> both 10. Set rdW=0 -> both 00.
- brch_takenE=1 together with load-use on rdE=7, rs2D=7 -> flashD=flashE=1, enbF=0; no hold.
- dmem_req=1, dmem_ack low for 4 cycles then high -> enbF/enbD/enbE=1 and nop_gen=1 for exactly 4 cycles. Back to RUN after the ack cycle. stall_cnt=4, mem_err=0.
- WAIT_MAX=8, dmem_req=1, dmem_ack never -> after 8 stall cycles state returns to RUN. mem_err=1 and stays 1 until rst.
- rst pulsed for 1 cycle mid-MEM_WAIT -> flashD=flashE=1 during rst. Afterwards state=RUN, stall_cnt=0, mem_err=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: hold/flush/bubble controls, E-stage forwarding selects, data-memory wait tracking.
// Latency: controls and forwarding are combinational from current inputs and FSM state; counters/flags update next posedge.
// Backpressure: a pending data-memory access holds F/D/E and injects a bubble until ack or timeout; a same-cycle ack costs nothing.
module hazard_ctrl #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic        we_regE,
    input  logic        ldE,
    input  logic [4:0]  rdM,
    input  logic        we_regM,
    input  logic [4:0]  rdW,
    input  logic        we_regW,
    input  logic        brch_takenE,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        enbF,
    output logic        enbD,
    output logic        enbE,
    output logic        flashD,
    output logic        flashE,
    output logic        nop_gen,
    output logic [1:0]  fwd_aE,
    output logic [1:0]  fwd_bE,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Last wait count before giving up on the memory.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q;
    logic [31:0] stall_cnt_q;

    logic timeout;
    logic memwait;
    logic ldu;

    assign timeout = (state_q == MEM_WAIT) && !dmem_ack && (wait_cnt_q == WAIT_LAST);
    assign memwait = ((state_q == RUN) && dmem_req && !dmem_ack) ||
                     ((state_q == MEM_WAIT) && !dmem_ack && !timeout);

    // Load in E whose destination is read by the instruction in D needs one bubble.
    assign ldu = ldE && we_regE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

    // Forwarding selects: M stage has priority over W; x0 never forwards.
    always_comb begin
        fwd_aE = 2'b00;
        fwd_bE = 2'b00;
        if (we_regM && (rdM != 5'd0) && (rdM == rs1E))
            fwd_aE = 2'b01;
        else if (we_regW && (rdW != 5'd0) && (rdW == rs1E))
            fwd_aE = 2'b10;
        if (we_regM && (rdM != 5'd0) && (rdM == rs2E))
            fwd_bE = 2'b01;
        else if (we_regW && (rdW != 5'd0) && (rdW == rs2E))
            fwd_bE = 2'b10;
    end

    // Pipeline control priority: reset, memory wait, taken branch, load-use.
    always_comb begin
        enbF    = 1'b0;
        enbD    = 1'b0;
        enbE    = 1'b0;
        flashD  = 1'b0;
        flashE  = 1'b0;
        nop_gen = 1'b0;
        if (rst) begin
            flashD = 1'b1;
            flashE = 1'b1;
        end else if (memwait) begin
            // Everything freezes, including a taken branch in E; it resolves after the wait.
            enbF    = 1'b1;
            enbD    = 1'b1;
            enbE    = 1'b1;
            nop_gen = 1'b1;
        end else if (brch_takenE) begin
            // D holds a wrong-path instruction, so any load-use stall on it is moot.
            flashD = 1'b1;
            flashE = 1'b1;
        end else if (ldu) begin
            enbF   = 1'b1;
            enbD   = 1'b1;
            flashE = 1'b1;
        end
    end

    // Next-state and wait counter for the memory-wait FSM.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 8'd0;
        case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ack)
                    state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (dmem_ack || timeout)
                    state_d = RUN;
                else
                    wait_cnt_d = wait_cnt_q + 8'd1;
            end
            default: state_d = RUN;
        endcase
    end

    // State, sticky timeout flag and stall performance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout)
                mem_err_q <= 1'b1;
            if (enbF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding, branch flush, memory wait, timeout and reset.
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later, well before the next edge.
// Memory handshakes are driven directly; every wait is a fixed cycle count.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        we_regE, ldE, we_regM, we_regW, brch_takenE, dmem_req, dmem_ack;
    logic        enbF, enbD, enbE, flashD, flashE, nop_gen, mem_err;
    logic [1:0]  fwd_aE, fwd_bE;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hazard_ctrl #(.WAIT_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .we_regE(we_regE), .ldE(ldE),
        .rdM(rdM), .we_regM(we_regM), .rdW(rdW), .we_regW(we_regW),
        .brch_takenE(brch_takenE), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .enbF(enbF), .enbD(enbD), .enbE(enbE), .flashD(flashD), .flashE(flashE),
        .nop_gen(nop_gen), .fwd_aE(fwd_aE), .fwd_bE(fwd_bE),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the six pipeline controls packed as {enbF,enbD,enbE,flashD,flashE,nop_gen}.
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, enbF, enbD, enbE, flashD, flashE, nop_gen}, {26'd0, exp});
    endtask

    task automatic clr_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        we_regE = 0; ldE = 0; we_regM = 0; we_regW = 0;
        brch_takenE = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        #1;
        chk_ctl("rst_ctl", 6'b000110);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk_ctl("idle_ctl", 6'b000000);
        chk("idle_fwd", {28'd0, fwd_aE, fwd_bE}, 32'd0);

        // Load-use: exactly one bubble.
        ldE = 1; we_regE = 1; rdE = 5; rs1D = 5;
        #1;
        chk_ctl("ldu_ctl", 6'b110010);
        tick();
        ldE = 0;
        #1;
        chk_ctl("ldu_after_ctl", 6'b000000);
        chk("ldu_stall_cnt", stall_cnt, 32'd1);

        // Load to x0 never stalls.
        ldE = 1; rdE = 0; rs1D = 0;
        #1;
        chk_ctl("ldu_x0_ctl", 6'b000000);
        clr_inputs();

        // Forwarding priority M over W, and x0 never forwards.
        we_regM = 1; rdM = 3; we_regW = 1; rdW = 3; rs1E = 3; rs2E = 3;
        #1;
        chk("fwd_m", {28'd0, fwd_aE, fwd_bE}, 32'b0101);
        rdM = 0;
        #1;
        chk("fwd_w", {28'd0, fwd_aE, fwd_bE}, 32'b1010);
        rdW = 0;
        #1;
        chk("fwd_none", {28'd0, fwd_aE, fwd_bE}, 32'b0000);
        rdM = 3; rdW = 4; rs2E = 4;
        #1;
        chk("fwd_split", {28'd0, fwd_aE, fwd_bE}, 32'b0110);
        we_regM = 0;
        #1;
        chk("fwd_no_we", {28'd0, fwd_aE, fwd_bE}, 32'b0010);
        clr_inputs();

        // Taken branch overrides load-use.
        brch_takenE = 1; ldE = 1; we_regE = 1; rdE = 7; rs2D = 7;
        #1;
        chk_ctl("brch_ctl", 6'b000110);
        tick();
        clr_inputs();
        #1;
        chk("brch_stall_cnt", stall_cnt, 32'd1);

        // Memory wait of 4 cycles, then ack; a branch during the wait is frozen.
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            brch_takenE = (i == 2);
            #1;
            chk_ctl($sformatf("mw_ctl_%0d", i), 6'b111001);
            tick();
        end
        brch_takenE = 0;
        dmem_ack = 1;
        #1;
        chk_ctl("mw_ack_ctl", 6'b000000);
        tick();
        dmem_req = 0; dmem_ack = 0;
        #1;
        chk_ctl("mw_run_ctl", 6'b000000);
        chk("mw_stall_cnt", stall_cnt, 32'd5);
        chk("mw_mem_err", {31'd0, mem_err}, 32'd0);

        // Same-cycle ack costs no stall.
        dmem_req = 1; dmem_ack = 1;
        #1;
        chk_ctl("ack0_ctl", 6'b000000);
        tick();
        clr_inputs();

        // Timeout with WAIT_MAX=8: eight stall cycles, then release and sticky error.
        dmem_req = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_ctl($sformatf("to_ctl_%0d", i), 6'b111001);
            tick();
        end
        #1;
        chk_ctl("to_release_ctl", 6'b000000);
        chk("to_err_before", {31'd0, mem_err}, 32'd0);
        tick();
        dmem_req = 0;
        #1;
        chk("to_mem_err", {31'd0, mem_err}, 32'd1);
        chk_ctl("to_run_ctl", 6'b000000);
        chk("to_stall_cnt", stall_cnt, 32'd13);
        tick();
        tick();
        chk("to_err_sticky", {31'd0, mem_err}, 32'd1);

        // Reset in the middle of a memory wait.
        dmem_req = 1;
        tick();
        tick();
        #1;
        chk_ctl("rw_wait_ctl", 6'b111001);
        rst = 1; dmem_req = 0;
        #1;
        chk_ctl("rw_rst_ctl", 6'b000110);
        tick();
        rst = 0;
        #1;
        chk("rw_stall_cnt", stall_cnt, 32'd0);
        chk("rw_mem_err", {31'd0, mem_err}, 32'd0);
        chk_ctl("rw_run_ctl", 6'b000000);
        tick();
        #1;
        chk("rw_stall_hold", stall_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
